// File: rtl/sp_wb_arbiter.sv
// Purpose : two-master round-robin arbiter for the 8-bit Wishbone service bus,
//           granting per whole cyc tenure, with a per-strobe ack watchdog.
// Latency : grant one cycle after cyc rises in IDLE; ack/err/read data are
//           combinational; at least one idle cycle between tenures.
// Backpressure: a master simply holds stb until ack or err; a silent slave is
//           turned into an err after TIMEOUT+1 strobe cycles.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   m{0,1}_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i   master requests
//   m{0,1}_dat_o/ack_o/err_o                     master responses
//   s_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o         slave-side bus
//   s_dat_i/s_ack_i                              slave responses
//   grant_o                   one-hot owner (bit 0 = master 0), 0 when idle
//   timeout_o                 sticky watchdog-error flag, cleared by reset only

module sp_wb_arbiter #(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [23:0] m0_adr_i,
  input  logic [7:0]  m0_dat_i,
  output logic [7:0]  m0_dat_o,
  input  logic        m0_we_i,
  input  logic [0:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [23:0] m1_adr_i,
  input  logic [7:0]  m1_dat_i,
  output logic [7:0]  m1_dat_o,
  input  logic        m1_we_i,
  input  logic [0:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [23:0] s_adr_o,
  output logic [7:0]  s_dat_o,
  output logic        s_we_o,
  output logic [0:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [7:0]  s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [TO_WIDTH-1:0] TIMEOUT_C = TO_WIDTH'(TIMEOUT);

  state_t              state_q, state_d;
  logic                last_q, last_d;     // last master served; 1 after reset so m0 wins the first tie
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                timeout_q, timeout_d;

  // Signals of whichever master currently owns the bus (all 0 in IDLE).
  logic                granted;
  logic [23:0]         mx_adr;
  logic [7:0]          mx_dat;
  logic                mx_we;
  logic [0:0]          mx_sel;
  logic                mx_stb;
  logic                mx_cyc;
  logic                wd_fire;
  logic                stb_out;
  logic                ack_out;

  // ------------------------------------------------------------------
  // Owner mux
  // ------------------------------------------------------------------
  always_comb begin
    granted = 1'b0;
    mx_adr  = '0;
    mx_dat  = '0;
    mx_we   = 1'b0;
    mx_sel  = '0;
    mx_stb  = 1'b0;
    mx_cyc  = 1'b0;
    case (state_q)
      GNT0: begin
        granted = 1'b1;
        mx_adr  = m0_adr_i;
        mx_dat  = m0_dat_i;
        mx_we   = m0_we_i;
        mx_sel  = m0_sel_i;
        mx_stb  = m0_stb_i;
        mx_cyc  = m0_cyc_i;
      end
      GNT1: begin
        granted = 1'b1;
        mx_adr  = m1_adr_i;
        mx_dat  = m1_dat_i;
        mx_we   = m1_we_i;
        mx_sel  = m1_sel_i;
        mx_stb  = m1_stb_i;
        mx_cyc  = m1_cyc_i;
      end
      default: ;
    endcase
  end

  // An ack arriving on the boundary cycle suppresses the fire, so ack wins.
  assign wd_fire = granted & (wd_q == TIMEOUT_C) & mx_stb & ~s_ack_i;

  // The fired strobe is withdrawn from the slave so a late ack cannot be
  // matched to a transfer the master has already seen fail.
  assign stb_out = mx_stb & mx_cyc & ~wd_fire;
  assign ack_out = s_ack_i & stb_out;

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign s_adr_o  = mx_adr;
  assign s_dat_o  = mx_dat;
  assign s_we_o   = mx_we;
  assign s_sel_o  = mx_sel;
  assign s_stb_o  = stb_out;
  assign s_cyc_o  = mx_cyc;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = (state_q == GNT0) & ack_out;
  assign m1_ack_o = (state_q == GNT1) & ack_out;
  assign m0_err_o = (state_q == GNT0) & wd_fire;
  assign m1_err_o = (state_q == GNT1) & wd_fire;

  assign grant_o   = {state_q == GNT1, state_q == GNT0};
  assign timeout_o = timeout_q;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = timeout_q | wd_fire;

    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      // Tenure ends only when the owner drops cyc; going through IDLE
      // guarantees one dead cycle before the other master can take over.
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counts consecutive unacknowledged strobe cycles of the owner.
  always_comb begin
    if (!granted || !mx_stb || s_ack_i || wd_fire) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + TO_WIDTH'(1);
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sp_wb_arbiter.sv
module tb_sp_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic [23:0] m0_adr_i, m1_adr_i;
  logic [7:0]  m0_dat_i, m1_dat_i;
  logic [7:0]  m0_dat_o, m1_dat_o;
  logic        m0_we_i, m1_we_i;
  logic [0:0]  m0_sel_i, m1_sel_i;
  logic        m0_stb_i, m1_stb_i;
  logic        m0_cyc_i, m1_cyc_i;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;
  logic [23:0] s_adr_o;
  logic [7:0]  s_dat_o;
  logic        s_we_o;
  logic [0:0]  s_sel_o;
  logic        s_stb_o;
  logic        s_cyc_o;
  logic [7:0]  s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  sp_wb_arbiter #(.TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled #2 later, well away from either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
    m0_we_i = 0; m1_we_i = 0; m0_sel_i = 1'b1; m1_sel_i = 1'b1;
    m0_stb_i = 0; m1_stb_i = 0; m0_cyc_i = 0; m1_cyc_i = 0;
    s_dat_i = '0; s_ack_i = 0;
    tick(); tick();
    #2;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_bus: cyc=%b stb=%b want 0 0", s_cyc_o, s_stb_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    m0_cyc_i = 1; m1_cyc_i = 1;
    #2;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", grant_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL tie_first_m0: grant=%b cyc=%b want 01 1", grant_o, s_cyc_o); end
    tick();
    m0_cyc_i = 0;          // m0 releases in this cycle
    #2;
    checks++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("FAIL tie_release: cyc=%b grant=%b want 0 01", s_cyc_o, grant_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL tie_gap: grant=%b cyc=%b want 00 0", grant_o, s_cyc_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL tie_m1_second: grant=%b cyc=%b want 10 1", grant_o, s_cyc_o); end
    tick();
    m1_cyc_i = 0;
    tick();
    m0_cyc_i = 1; m1_cyc_i = 1;   // second tie, last served was m1
    #2;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL tie2_idle: got %b want 00", grant_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL tie2_m0: got %b want 01", grant_o); end
    tick();
    m0_cyc_i = 0; m1_cyc_i = 0;
    tick(); tick();
  endtask

  task automatic test_single_master();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 24'h800000;
    #2;
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL sm_latency: cyc=%b want 0", s_cyc_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 24'h800000) begin
      errors++; $display("FAIL sm_grant: grant=%b stb=%b adr=%h want 01 1 800000", grant_o, s_stb_o, s_adr_o); end
    checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL sm_early_ack: got %b want 0", m0_ack_o); end
    tick();
    s_ack_i = 1; s_dat_i = 8'hA5;
    #2;
    checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 8'hA5 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL sm_ack: ack0=%b dat=%h ack1=%b want 1 a5 0", m0_ack_o, m0_dat_o, m1_ack_o); end
    tick();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #2;
    checks++; if (m0_ack_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("FAIL sm_ack_pulse: ack=%b grant=%b want 0 01", m0_ack_o, grant_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL sm_idle: got %b want 00", grant_o); end
  endtask

  task automatic test_locked_tenure();
    logic [7:0] bytes [4];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 24'h000100; m0_dat_i = bytes[0];
    tick();
    m1_cyc_i = 1; m1_stb_i = 1;
    for (int i = 0; i < 4; i++) begin
      m0_dat_i = bytes[i]; m0_adr_i = 24'h000100 + 24'(i); s_ack_i = 1;
      #2;
      checks++; if (s_dat_o !== bytes[i] || s_we_o !== 1'b1 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || grant_o !== 2'b01) begin
        errors++; $display("FAIL lock_byte%0d: dat=%h we=%b ack0=%b ack1=%b grant=%b want %h 1 1 0 01",
                           i, s_dat_o, s_we_o, m0_ack_o, m1_ack_o, grant_o, bytes[i]); end
      tick();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #2;
    checks++; if (grant_o !== 2'b01 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL lock_release: grant=%b ack1=%b want 01 0", grant_o, m1_ack_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b00 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL lock_gap: grant=%b ack1=%b want 00 0", grant_o, m1_ack_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL lock_m1_after: got %b want 10", grant_o); end
    tick();
    m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      #2;
      checks++; if (m1_err_o !== (k == 5) || s_stb_o !== (k != 5) || m0_err_o !== 1'b0 || timeout_o !== 1'b0) begin
        errors++; $display("FAIL to_cycle%0d: err1=%b stb=%b err0=%b to=%b want %b %b 0 0",
                           k, m1_err_o, s_stb_o, m0_err_o, timeout_o, k == 5, k != 5); end
      tick();
    end
    #2;
    checks++; if (timeout_o !== 1'b1 || m1_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
      errors++; $display("FAIL to_after: to=%b err1=%b stb=%b want 1 0 1", timeout_o, m1_err_o, s_stb_o); end
    tick();
    m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick(); #2;
    checks++; if (timeout_o !== 1'b1 || m0_err_o !== 1'b0) begin errors++; $display("FAIL to_sticky: to=%b err0=%b want 1 0", timeout_o, m0_err_o); end
  endtask

  task automatic test_ack_boundary();
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      s_ack_i = (k == 5);
      #2;
      if (k == 5) begin
        checks++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
          errors++; $display("FAIL ackb_boundary: ack=%b err=%b stb=%b want 1 0 1", m0_ack_o, m0_err_o, s_stb_o); end
      end
      tick();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #2;
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL ackb_timeout: got %b want 0", timeout_o); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 0;
    tick(); #2;
    checks++; if (grant_o !== 2'b10 || s_stb_o !== 1'b1) begin errors++; $display("FAIL rm_grant: grant=%b stb=%b want 10 1", grant_o, s_stb_o); end
    s_ack_i = 1;
    #1;
    reset_n = 0;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00 || m1_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL rm_drop: cyc=%b stb=%b grant=%b err=%b ack=%b want 0 0 00 0 0",
                         s_cyc_o, s_stb_o, grant_o, m1_err_o, m1_ack_o); end
    tick();
    s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    reset_n = 1;
    #2;
    checks++; if (grant_o !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("FAIL rm_idle: grant=%b to=%b want 00 0", grant_o, timeout_o); end
    tick(); #2;
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rm_m0_first: got %b want 01", grant_o); end
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single_master();
    test_locked_tenure();
    test_timeout();
    test_ack_boundary();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
